// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse converter with per-channel sync, edge mode and retrigger.
// Optional sticky retrigger flag enabled with `define MEP_OVF_FLAG_EN.
module multi_edge_pulse_gen #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_CH-1:0]     LVL_SIG,
  input  logic [2*NUM_CH-1:0]   EDGE_MODE,
  input  logic [NUM_CH-1:0]     OVF_CLR,
  output logic [NUM_CH-1:0]     PULSE_SIG,
  output logic [NUM_CH-1:0]     OVF
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = LVL_SIG;
  end else begin : g_sync
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int i = 0; i < SYNC_STAGES; i++)
          sync_q[i] <= '0;
      end else begin
        sync_q[0] <= LVL_SIG;
        for (int i = 1; i < SYNC_STAGES; i++)
          sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // History tracks S in every mode so re-enabling never sees a stale edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) d <= '0;
    else      d <= s;
  end

`ifndef MEP_OVF_FLAG_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^OVF_CLR;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]    mode;
    logic          rise;
    logic          fall;
    logic          tr;
    logic          busy;
    logic [CW-1:0] cnt;
    logic          pulse_q;

    assign mode = EDGE_MODE[2*c +: 2];
    assign rise = s[c] & ~d[c];
    assign fall = ~s[c] & d[c];
    assign busy = (cnt > ONE);

    always_comb begin
      tr = 1'b0;
      unique case (mode)
        2'b00: tr = rise;
        2'b01: tr = fall;
        2'b10: tr = rise | fall;
        2'b11: tr = 1'b0;
      endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        cnt     <= '0;
        pulse_q <= 1'b0;
      end else begin
        if (tr)
          cnt <= LOAD;
        else if (cnt != '0)
          cnt <= cnt - ONE;
        pulse_q <= tr | busy;
      end
    end

    assign PULSE_SIG[c] = pulse_q;

`ifdef MEP_OVF_FLAG_EN
    logic ovf_q;

    // Set beats clear when a retrigger lands on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
        ovf_q <= 1'b0;
      else if (tr && busy)
        ovf_q <= 1'b1;
      else if (OVF_CLR[c])
        ovf_q <= 1'b0;
    end

    assign OVF[c] = ovf_q;
`else
    assign OVF[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Self-checking bench: three configurations driven in parallel, checked
// every cycle against an edge-timeline model of the pulse rules.
module tb_multi_edge_pulse_gen;

  localparam int N = 4;

  logic         CLK;
  logic         RST;
  logic [N-1:0] lvl;
  logic [2*N-1:0] mode;
  logic [N-1:0] clr;

  logic [N-1:0] pls  [3];
  logic [N-1:0] ovfs [3];

  int sy_of [3] = '{2, 0, 1};
  int pl_of [3] = '{1, 4, 8};

  logic [N-1:0] hist [3][0:8191];
  int           kc   [3];
  int           endt [3][N];
  logic [N-1:0] ovf_m [3];
  logic [N-1:0] exp_p [3];

  int checks = 0;
  int errors = 0;

  multi_edge_pulse_gen #(.NUM_CH(N), .SYNC_STAGES(2), .PULSE_LEN(1)) u0 (
    .CLK(CLK), .RST(RST), .LVL_SIG(lvl), .EDGE_MODE(mode),
    .OVF_CLR(clr), .PULSE_SIG(pls[0]), .OVF(ovfs[0]));

  multi_edge_pulse_gen #(.NUM_CH(N), .SYNC_STAGES(0), .PULSE_LEN(4)) u1 (
    .CLK(CLK), .RST(RST), .LVL_SIG(lvl), .EDGE_MODE(mode),
    .OVF_CLR(clr), .PULSE_SIG(pls[1]), .OVF(ovfs[1]));

  multi_edge_pulse_gen #(.NUM_CH(N), .SYNC_STAGES(1), .PULSE_LEN(8)) u2 (
    .CLK(CLK), .RST(RST), .LVL_SIG(lvl), .EDGE_MODE(mode),
    .OVF_CLR(clr), .PULSE_SIG(pls[2]), .OVF(ovfs[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: a trigger at edge k keeps the pulse high after edges k..k+PL-1.
  task automatic model_edge(input int j);
    int k;
    logic [N-1:0] s;
    logic [N-1:0] d;
    logic t;
    logic set;
    k = kc[j];
    hist[j][k] = lvl;
    s = (k >= sy_of[j]) ? hist[j][k - sy_of[j]] : '0;
    d = (k >= 1 && k - 1 >= sy_of[j]) ? hist[j][k - 1 - sy_of[j]] : '0;
    for (int c = 0; c < N; c++) begin
      case (mode[2*c +: 2])
        2'b00:   t = s[c] & ~d[c];
        2'b01:   t = ~s[c] & d[c];
        2'b10:   t = s[c] ^ d[c];
        default: t = 1'b0;
      endcase
      set = 1'b0;
      if (t) begin
        set = (k < endt[j][c]);
        endt[j][c] = k + pl_of[j];
      end
      if (set)
        ovf_m[j][c] = 1'b1;
      else if (clr[c])
        ovf_m[j][c] = 1'b0;
      exp_p[j][c] = (k < endt[j][c]);
    end
    kc[j] = k + 1;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      kc[j] = 0;
      ovf_m[j] = '0;
      exp_p[j] = '0;
      for (int c = 0; c < N; c++)
        endt[j][c] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eo;
    for (int j = 0; j < 3; j++) begin
      checks++;
      assert (pls[j] === exp_p[j]) else begin
        errors++;
        $error("FAIL %s pulse dut%0d t=%0t: got %b want %b",
               tag, j, $time, pls[j], exp_p[j]);
      end
`ifdef MEP_OVF_FLAG_EN
      eo = ovf_m[j];
`else
      eo = '0;
`endif
      checks++;
      assert (ovfs[j] === eo) else begin
        errors++;
        $error("FAIL %s ovf dut%0d t=%0t: got %b want %b",
               tag, j, $time, ovfs[j], eo);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] l, input string tag);
    lvl = l;
    @(posedge CLK);
    if (RST)
      for (int j = 0; j < 3; j++) model_edge(j);
    @(negedge CLK);
    check_all(tag);
    clr = '0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (n) @(negedge CLK);
    check_all("in_rst");
    RST = 1'b1;
  endtask

  int hi_cnt;

  initial begin
    RST  = 1'b0;
    lvl  = '0;
    mode = '0;
    clr  = '0;
    @(negedge CLK);
    do_reset(3);

    repeat (8) step(4'b0000, "idle");

    // single rise then fall, mode 00 everywhere
    repeat (6) step(4'b0001, "rise0");
    repeat (10) step(4'b0000, "fall0");

    // ch1 fall-only, ch2 both edges
    mode = 8'b00_10_01_00;
    repeat (10) step(4'b0110, "ch12_hi");
    repeat (10) step(4'b0000, "ch12_lo");

    // two edges two cycles apart, mode both: retrigger extends the pulse
    mode = 8'b10_10_10_10;
    hi_cnt = 0;
    step(4'b0001, "retrig");
    hi_cnt += int'(pls[1][0]);
    step(4'b0001, "retrig");
    hi_cnt += int'(pls[1][0]);
    step(4'b0000, "retrig");
    hi_cnt += int'(pls[1][0]);
    repeat (10) begin
      step(4'b0000, "retrig");
      hi_cnt += int'(pls[1][0]);
    end
    checks++;
    assert (hi_cnt == 2 + 4) else begin
      errors++;
      $error("FAIL retrig_width: got %0d want %0d", hi_cnt, 2 + 4);
    end
    clr = 4'b0001;
    step(4'b0000, "ovf_clr");
    repeat (2) step(4'b0000, "ovf_clr");

    // PULSE_LEN=1 with a toggle every cycle
    for (int i = 0; i < 8; i++)
      step((i % 2 == 0) ? 4'b0001 : 4'b0000, "toggle");
    repeat (4) step(4'b0000, "toggle");

    // ch3 disabled, then re-enabled while input is high
    mode = 8'b11_00_00_00;
    repeat (5) step(4'b1000, "dis3");
    mode = 8'b00_00_00_00;
    repeat (5) step(4'b1000, "reen3");
    repeat (5) step(4'b0000, "reen3");
    repeat (10) step(4'b1000, "reen3");

    // reset in the middle of a long pulse
    repeat (4) step(4'b0000, "pre_mid");
    repeat (4) step(4'b0001, "mid_pulse");
    #2;
    do_reset(2);
    repeat (12) step(4'b0001, "post_rst");
    repeat (4) step(4'b0000, "post_rst");

    // reset release with ch0 already high
    do_reset(2);
    repeat (12) step(4'b0001, "rel_hi");

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0)
        mode = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        clr = 4'($urandom);
      if ($urandom_range(0, 3) == 0)
        step(4'($urandom), "rand");
      else
        step(lvl, "rand");
      if ($urandom_range(0, 299) == 0)
        do_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
